rr_encoder: RTL

Registered round-robin encoder: the inverse of the team's one-hot `Decoder`. It compresses a request vector of `WIDTH` lines into a binary index plus the matching one-hot grant. Results leave through a valid/ready output stage. It sits in front of shared resources, such as a register-file write port or a bus master mux, where several requesters must be serialized fairly. Its `code` output feeds a `Decoder` of the same `WIDTH` directly.

---
 rtl/rr_encoder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/rr_encoder.sv
// rr_encoder
//   Registered round-robin encoder. It compresses a request vector into the
//   binary index of the granted line plus the matching one-hot grant.
//   Results leave through a valid/ready output stage. After each grant the
//   priority pointer moves to the line after the winner, so requesters are
//   served fairly.
//
// Parameters
//   WIDTH      number of request lines (2..256, any value)
//   ADDR_SIZE  width of the encoded index, derived from WIDTH
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req        in   request levels, sampled every rising edge
//   enable     in   when low, no new request is captured
//   out_ready  in   downstream accepts the current result
//   out_valid  out  code/onehot/multi hold a result
//   code       out  binary index of the granted request
//   onehot     out  1 << code while out_valid, else zero
//   multi      out  more than one req bit was set at the capture edge
module rr_encoder #(
  parameter int WIDTH     = 16,
  parameter int ADDR_SIZE = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     req,
  input  logic                 enable,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [ADDR_SIZE-1:0] code,
  output logic [WIDTH-1:0]     onehot,
  output logic                 multi
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_SIZE-1:0]   ptr_q, ptr_d;
  logic [ADDR_SIZE-1:0]   code_q, code_d;
  logic [WIDTH-1:0]       onehot_q, onehot_d;
  logic                   multi_q, multi_d;

  logic [2*WIDTH-1:0]     req_dbl_s;
  logic [WIDTH-1:0]       req_rot_s;
  logic [ADDR_SIZE-1:0]   offset_s;
  logic [ADDR_SIZE:0]     sum_s;
  logic [ADDR_SIZE:0]     wrap_s;
  logic [ADDR_SIZE-1:0]   winner_s;
  logic [ADDR_SIZE-1:0]   ptr_next_s;
  logic                   any_req_s;
  logic                   multi_req_s;
  logic                   load_s;

  // Winner search: rotate req so bit 0 is the pointer line, then take the
  // lowest set bit and map that offset back to an absolute index.
  always_comb begin
    req_dbl_s = {req, req} >> ptr_q;
    req_rot_s = req_dbl_s[WIDTH-1:0];
    offset_s  = '0;
    // Scan downward so the lowest set offset is the last one written.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_rot_s[i]) begin
        offset_s = ADDR_SIZE'(i);
      end else begin
        offset_s = offset_s;
      end
    end
    // ptr and offset are both below WIDTH, so one conditional subtract wraps.
    sum_s = {1'b0, ptr_q} + {1'b0, offset_s};
    if (sum_s >= (ADDR_SIZE+1)'(WIDTH)) begin
      wrap_s = sum_s - (ADDR_SIZE+1)'(WIDTH);
    end else begin
      wrap_s = sum_s;
    end
    winner_s = wrap_s[ADDR_SIZE-1:0];
    // Explicit wrap at WIDTH-1 keeps ptr legal for non-power-of-two WIDTH.
    if (winner_s == ADDR_SIZE'(WIDTH - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = winner_s + ADDR_SIZE'(1);
    end
    any_req_s   = |req;
    // x & (x-1) clears the lowest set bit; anything left means popcount > 1.
    multi_req_s = |(req & (req - WIDTH'(1)));
    load_s      = enable & any_req_s & ((state_q == ST_EMPTY) | out_ready);
  end

  // Output-stage FSM: next state and next output register values.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    code_d   = code_q;
    onehot_d = onehot_q;
    multi_d  = multi_q;
    case (state_q)
      ST_EMPTY: begin
        if (load_s) begin
          state_d  = ST_FULL;
          ptr_d    = ptr_next_s;
          code_d   = winner_s;
          onehot_d = WIDTH'(1) << winner_s;
          multi_d  = multi_req_s;
        end else begin
          state_d  = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (load_s) begin
          // Accept and reload in the same cycle: no bubble.
          state_d  = ST_FULL;
          ptr_d    = ptr_next_s;
          code_d   = winner_s;
          onehot_d = WIDTH'(1) << winner_s;
          multi_d  = multi_req_s;
        end else if (out_ready) begin
          // Drain: code and multi keep their last value.
          state_d  = ST_EMPTY;
          onehot_d = '0;
        end else begin
          state_d  = ST_FULL;
        end
      end
      default: begin
        state_d  = ST_EMPTY;
        onehot_d = '0;
      end
    endcase
  end

  // State, pointer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      ptr_q    <= '0;
      code_q   <= '0;
      onehot_q <= '0;
      multi_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      code_q   <= code_d;
      onehot_q <= onehot_d;
      multi_q  <= multi_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign code      = code_q;
  assign onehot    = onehot_q;
  assign multi     = multi_q;

endmodule
